// File: rtl/top_level_pkg.sv
// Shared types and constants for the top_level 8x8 signed multiply sequencer.
package top_level_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Sequencer program counter steps.
  localparam logic [7:0] LD_A      = 8'd0;
  localparam logic [7:0] LD_B      = 8'd1;
  localparam logic [7:0] MUL_FIRST = 8'd2;
  localparam logic [7:0] MUL_LAST  = 8'd9;
  localparam logic [7:0] ST_LO     = 8'd10;
  localparam logic [7:0] ST_HI     = 8'd11;

  // Data memory byte addresses.
  localparam logic [7:0] ADDR_A  = 8'd0;
  localparam logic [7:0] ADDR_B  = 8'd1;
  localparam logic [7:0] ADDR_LO = 8'd2;
  localparam logic [7:0] ADDR_HI = 8'd3;

endpackage

// File: rtl/top_level_data_mem.sv
// Byte-addressed data memory: combinational read, synchronous write, no reset.
module data_mem #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [DataWidth-1:0] core_memory [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      core_memory[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = core_memory[addr_i];

endmodule

// File: rtl/top_level.sv
// Sequenced signed 8x8 multiplier over a 256x8 data memory; a falling edge on start runs it.
// Optional simulation trace of each result when TOP_LEVEL_TRACE_EN is defined.
module top_level
  import top_level_pkg::*;
#(
  parameter int unsigned PROG_LENGTH = 119
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam logic [7:0] PcLast = 8'(PROG_LENGTH - 1);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  pc;
  logic        start_q;
  logic        start_fall;
  logic        run;

  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;

  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  assign pc         = pc_q;
  assign start_fall = start_q & ~start;
  assign run        = (state_q == RUN);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= 8'd0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      start_q <= start;
    end
  end

  // Next state; a start falling edge while running is deliberately not decoded.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        if (start_fall) begin
          state_d = RUN;
        end
      end
      RUN: begin
        pc_d = pc_q + 8'd1;
        // Enter DONE on the same edge pc reaches PROG_LENGTH.
        if (pc_q == PcLast) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start_fall) begin
          state_d = RUN;
          pc_d    = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = 8'd0;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    done = (state_q == DONE);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= 16'd0;
      mplier_q <= 8'd0;
      acc_q    <= 16'd0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // Shift-add: multiplicand moves left, multiplier right; bit 7 carries weight -2^7.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (run) begin
      if (pc_q == LD_A) begin
        mcand_d = {{8{mem_rdata[7]}}, mem_rdata};
      end else if (pc_q == LD_B) begin
        mplier_d = mem_rdata;
        acc_d    = 16'd0;
      end else if (pc_q >= MUL_FIRST && pc_q <= MUL_LAST) begin
        if (mplier_q[0]) begin
          acc_d = (pc_q == MUL_LAST) ? (acc_q - mcand_q) : (acc_q + mcand_q);
        end
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[7:1]};
      end
    end
  end

  // Memory port steering.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = acc_q[7:0];
    mem_addr  = ADDR_A;
    if (pc_q == LD_B) begin
      mem_addr = ADDR_B;
    end else if (pc_q == ST_LO) begin
      mem_addr = ADDR_LO;
      mem_we   = run;
    end else if (pc_q == ST_HI) begin
      mem_addr  = ADDR_HI;
      mem_wdata = acc_q[15:8];
      mem_we    = run;
    end
  end

  data_mem #(
    .AddrWidth(8),
    .DataWidth(8)
  ) my_data_mem (
    .clk_i  (clk),
    .addr_i (mem_addr),
    .we_i   (mem_we),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

`ifdef TOP_LEVEL_TRACE_EN
  always @(posedge clk) begin
    if (state_q == RUN && state_d == DONE) begin
      $display("%0d * %0d = %0d",
               $signed(my_data_mem.core_memory[ADDR_A]),
               $signed(my_data_mem.core_memory[ADDR_B]),
               $signed({my_data_mem.core_memory[ADDR_HI], my_data_mem.core_memory[ADDR_LO]}));
    end
  end
`else
`endif

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: vector table, sampled sweep and multi-cycle corner cases.
module tb_top_level;

  localparam int unsigned PL = 119;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    int          a;
    int          b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  top_level #(
    .PROG_LENGTH(PL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .done (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Measures posedges from the detecting edge until done is seen high.
  task automatic wait_done(output int lat);
    @(posedge clk);
    #1;
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic collect(input string name);
    logic [15:0] got;
    logic [15:0] exp;
    got = {dut.my_data_mem.core_memory[3], dut.my_data_mem.core_memory[2]};
    check({name, "_done"}, 32'(done), 32'd1);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_sb: got result 0x%0h, required a queued expectation", name, got);
    end else begin
      exp = sb_q.pop_front();
      check(name, 32'(got), 32'(exp));
    end
  endtask

  task automatic load_ops(input int a, input int b, input logic [15:0] exp);
    dut.my_data_mem.core_memory[0] = 8'(a);
    dut.my_data_mem.core_memory[1] = 8'(b);
    sb_q.push_back(exp);
  endtask

  task automatic run_op(input int a, input int b, input logic [15:0] exp, input string name,
                        input logic chk_lat);
    int lat;
    @(negedge clk);
    load_ops(a, b, exp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    if (chk_lat) check({name, "_lat"}, 32'(lat), 32'(PL));
    collect(name);
  endtask

  initial begin
    int lat;
    int a;
    int b;
    logic [7:0] m0;
    logic [7:0] m1;

    vecs[0] = '{a: 3,    b: 5,    exp: 16'h000F};
    vecs[1] = '{a: -64,  b: 63,   exp: 16'hF040};
    vecs[2] = '{a: -64,  b: -64,  exp: 16'h1000};
    vecs[3] = '{a: -128, b: -128, exp: 16'h4000};
    vecs[4] = '{a: 127,  b: -128, exp: 16'hC080};
    vecs[5] = '{a: 127,  b: 127,  exp: 16'h3F01};
    vecs[6] = '{a: 0,    b: -1,   exp: 16'h0000};
    vecs[7] = '{a: -1,   b: -1,   exp: 16'h0001};
    vecs[8] = '{a: -128, b: 127,  exp: 16'hC080};
    vecs[9] = '{a: 1,    b: -128, exp: 16'hFF80};

    reset = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pc", 32'(dut.pc), 32'd0);
    check("reset_start_q", 32'(dut.start_q), 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_pc", 32'(dut.pc), 32'd0);

    // Back-to-back runs through DONE -> RUN.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), 1'b1);
    end

    // DONE holds with pc frozen.
    repeat (5) @(posedge clk);
    #1;
    check("hold_done", 32'(done), 32'd1);
    check("hold_pc", 32'(dut.pc), 32'(PL));

    // Reset at pc 5 aborts the run; memory is untouched.
    @(negedge clk);
    dut.my_data_mem.core_memory[2] = 8'hA5;
    dut.my_data_mem.core_memory[3] = 8'h5A;
    dut.my_data_mem.core_memory[0] = 8'd7;
    dut.my_data_mem.core_memory[1] = 8'hF7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (dut.pc != 8'd5 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("abort_pc5", 32'(dut.pc), 32'd5);
    #1;
    reset = 1'b0;
    #1;
    check("abort_done", 32'(done), 32'd0);
    check("abort_pc", 32'(dut.pc), 32'd0);
    check("abort_mem0", 32'(dut.my_data_mem.core_memory[0]), 32'h07);
    check("abort_mem1", 32'(dut.my_data_mem.core_memory[1]), 32'hF7);
    check("abort_mem2", 32'(dut.my_data_mem.core_memory[2]), 32'hA5);
    check("abort_mem3", 32'(dut.my_data_mem.core_memory[3]), 32'h5A);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    run_op(7, -9, 16'hFFC1, "after_abort", 1'b1);

    // Start toggling mid-run is ignored.
    @(negedge clk);
    load_ops(-100, 37, 16'hF18C);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 20) start = 1'b1;
      if (lat == 21) start = 1'b0;
    end
    check("toggle_lat", 32'(lat), 32'(PL));
    collect("toggle");
    repeat (4) @(posedge clk);
    #1;
    check("toggle_stay_done", 32'(done), 32'd1);

    // Start falling exactly at reset release is seen on the first clock.
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    load_ops(-2, 50, 16'hFF9C);
    reset = 1'b1;
    start = 1'b0;
    wait_done(lat);
    check("rel_lat", 32'(lat), 32'(PL));
    collect("rel");

    // Sampled sweep over -64..63, endpoints included, reset before each pair.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = -64 + (i * 127) / 15;
        b = -64 + (j * 127) / 15;
        pulse_reset();
        check($sformatf("sweep_rst_done_%0d_%0d", a, b), 32'(done), 32'd0);
        run_op(a, b, 16'(a * b), $sformatf("sweep_%0d_%0d", a, b), 1'b0);
      end
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    m0 = dut.my_data_mem.core_memory[0];
    m1 = dut.my_data_mem.core_memory[1];
    check("sweep_last_opa", 32'(m0), 32'h3F);
    check("sweep_last_opb", 32'(m1), 32'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
